mem_chunk_packer: RTL and testbench

Inverse of the line-to-chunk serializer: accepts a stream of 16-bit chunks with a write strobe and reassembles them, lowest slice first, into a 480-bit line word.
Each completed line is presented to the VGA line store through a valid/ready handshake.
It sits between the memory-side chunk stream and the 480-bit scanline storage.
One assembly buffer plus one output register, so filling the next line overlaps with the consumer draining the previous one.

---
 rtl/mem_chunk_pkg.sv | 22 ++
 rtl/mem_chunk_packer.sv | 134 +++++++++++++
 tb/tb_mem_chunk_packer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_chunk_pkg.sv
// Shared geometry for the chunk serializer/packer pair and the packer FSM encoding.
package mem_chunk_pkg;

  localparam int CHUNK_W = 16;                 // bits per chunk
  localparam int CHUNKS  = 30;                 // chunks per line
  localparam int LINE_W  = CHUNK_W * CHUNKS;   // assembled line width (480)
  localparam int IDX_W   = 5;                  // chunk index width, 2**IDX_W >= CHUNKS

  // Index of the final slot in a line; reaching it with a write ends the fill.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic {
    FILL  = 1'b0,   // accepting chunks into the assembly buffer
    FLUSH = 1'b1    // buffer complete, waiting for the output register to free up
  } state_t;

  // Bit offset of a chunk slot inside a line word.
  function automatic int slot_lsb(input logic [IDX_W-1:0] idx);
    return int'(idx) * CHUNK_W;
  endfunction

endpackage

// File: rtl/mem_chunk_packer.sv
// Reassembles a stream of 16-bit chunks (lowest slice first) into 480-bit lines.
// One assembly buffer fills while the output register holds the previous line for
// the consumer; a completed buffer moves to the output when the slot is free or is
// being consumed on the same edge, so back-to-back lines leave no bubble.
module mem_chunk_packer
  import mem_chunk_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_wr_en,
  input  logic               in_sol,
  output logic               in_ready,
  output logic [LINE_W-1:0]  line_data,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [IDX_W-1:0]   chunk_idx,
  output logic               sync_err,
  input  logic               clr_err
);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [LINE_W-1:0]  r_asm;
  logic [LINE_W-1:0]  r_line;
  logic               r_valid;
  logic               r_err;

  logic               w_accept;
  logic [IDX_W-1:0]   w_slot;
  logic               w_last;
  logic               w_flush;
  logic               w_consume;
  logic               w_sol_err;

  // A write strobe only counts while the packer is ready; in FLUSH it is dropped silently.
  assign w_accept  = in_wr_en & in_ready;

  // A start-of-line chunk always lands in slot 0 and restarts the line from there.
  assign w_slot    = in_sol ? '0 : r_idx;

  // The line is complete when the slot being written is the final one. With a
  // single-chunk line a start-of-line chunk is also the last chunk.
  assign w_last    = (w_slot == LAST_IDX);

  // Start-of-line while a line is partially filled means the stream lost sync.
  assign w_sol_err = w_accept & in_sol & (r_idx != '0);

  // Move the finished buffer out when the output register is empty or is being
  // taken by the consumer on this very edge.
  assign w_flush   = (r_state == FLUSH) & (~r_valid | line_ready);

  assign w_consume = r_valid & line_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: fill until the last slot is written, then wait for the output slot.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_accept && w_last) w_state_next = FLUSH;
      FLUSH:   if (w_flush)            w_state_next = FILL;
      default:                         w_state_next = FILL;
    endcase
  end

  // FSM outputs: chunks are accepted only while filling.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      FILL:    in_ready = 1'b1;
      FLUSH:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Chunk index: advance past each written slot, hold on the last one until the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_flush) begin
      r_idx <= '0;
    end else if (w_accept && !w_last) begin
      r_idx <= w_slot + IDX_W'(1);
    end
  end

  // Assembly buffer: write the accepted chunk into its slot; old slots are simply overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else if (w_accept) begin
      r_asm[slot_lsb(w_slot) +: CHUNK_W] <= in_data;
    end
  end

  // Output register: load on flush (even while being consumed), otherwise drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line  <= '0;
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_line  <= r_asm;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky sync error: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_sol_err) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign line_data  = r_line;
  assign line_valid = r_valid;
  assign chunk_idx  = r_idx;
  assign sync_err   = r_err;

endmodule

// File: tb/tb_mem_chunk_packer.sv
// Directed bench for mem_chunk_packer: a small line model pushes expected lines to a
// queue as chunks are accepted; every consumed line is popped and compared.
module tb_mem_chunk_packer;
  import mem_chunk_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [CHUNK_W-1:0] in_data;
  logic               in_wr_en;
  logic               in_sol;
  logic               in_ready;
  logic [LINE_W-1:0]  line_data;
  logic               line_valid;
  logic               line_ready;
  logic [IDX_W-1:0]   chunk_idx;
  logic               sync_err;
  logic               clr_err;

  mem_chunk_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_wr_en   (in_wr_en),
    .in_sol     (in_sol),
    .in_ready   (in_ready),
    .line_data  (line_data),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .chunk_idx  (chunk_idx),
    .sync_err   (sync_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  logic [LINE_W-1:0] exp_q[$];
  logic [LINE_W-1:0] m_asm;
  logic [LINE_W-1:0] line_a;
  logic [LINE_W-1:0] line_b;
  logic [LINE_W-1:0] popped;
  int                m_idx = 0;
  int                errors = 0;
  int                checks = 0;
  int                lines_seen = 0;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkn(input string tag, input logic [IDX_W-1:0] obs, input logic [IDX_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk16(input string tag, input logic [CHUNK_W-1:0] obs, input logic [CHUNK_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check any handshake seen at the falling edge, then step to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n === 1'b1 && line_valid === 1'b1 && line_ready === 1'b1) begin
      chk1("line_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        chkl("line_data", line_data, popped);
        lines_seen++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one chunk, waiting (bounded) for in_ready, and update the line model on acceptance.
  task automatic send(input logic [CHUNK_W-1:0] d, input logic sol);
    int budget;
    budget = 200;
    while (in_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    chk1("in_ready_wait", in_ready, 1'b1);
    in_data  = d;
    in_sol   = sol;
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    in_sol   = 1'b0;
    if (sol) begin
      m_asm[CHUNK_W-1:0] = d;
      m_idx = 1;
    end else begin
      m_asm[m_idx*CHUNK_W +: CHUNK_W] = d;
      m_idx++;
    end
    if (m_idx == CHUNKS) begin
      exp_q.push_back(m_asm);
      m_idx = 0;
    end
  endtask

  task automatic send_line(input int base);
    for (int k = 0; k < CHUNKS; k++) send(CHUNK_W'(base + k), 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_wr_en   = 1'b0;
    in_sol     = 1'b0;
    line_ready = 1'b0;
    clr_err    = 1'b0;
    m_asm      = '0;

    // Reset state.
    tick();
    tick();
    chk1("rst_line_valid", line_valid, 1'b0);
    chkl("rst_line_data", line_data, '0);
    chkn("rst_chunk_idx", chunk_idx, '0);
    chk1("rst_sync_err", sync_err, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("rst_in_ready", in_ready, 1'b1);

    // Single line with the consumer always ready: valid one cycle after the last accept.
    line_ready = 1'b1;
    send_line(16'h1000);
    chk1("t1_flush_in_ready", in_ready, 1'b0);
    chk1("t1_not_yet_valid", line_valid, 1'b0);
    chkn("t1_idx_last", chunk_idx, IDX_W'(CHUNKS - 1));
    tick();
    chk1("t1_valid", line_valid, 1'b1);
    chkn("t1_idx_zero", chunk_idx, '0);
    chk1("t1_in_ready_back", in_ready, 1'b1);
    chk16("t1_slot29", line_data[29*CHUNK_W +: CHUNK_W], 16'h101D);
    tick();
    chk1("t1_valid_drop", line_valid, 1'b0);

    // Two back-to-back lines under backpressure; line 2 replaces line 1 on the consuming edge.
    line_ready = 1'b0;
    send_line(16'h2000);
    line_a = exp_q[$];
    tick();
    chk1("t2_a_valid", line_valid, 1'b1);
    send_line(16'h3000);
    line_b = exp_q[$];
    for (int i = 0; i < 5; i++) begin
      chk1("t2_backpressure", in_ready, 1'b0);
      chk1("t2_hold_valid", line_valid, 1'b1);
      chkl("t2_hold_data", line_data, line_a);
      tick();
    end
    line_ready = 1'b1;
    tick();
    chk1("t2_b_valid", line_valid, 1'b1);
    chkl("t2_b_data", line_data, line_b);
    tick();
    chk1("t2_drained", line_valid, 1'b0);

    // Start-of-line after 7 chunks: error flagged, line restarts at slot 1.
    for (int k = 0; k < 7; k++) send(CHUNK_W'(16'h4000 + k), 1'b0);
    send(16'hABCD, 1'b1);
    chk1("t4_sync_err", sync_err, 1'b1);
    chkn("t4_idx_one", chunk_idx, IDX_W'(1));
    for (int k = 1; k < CHUNKS; k++) send(CHUNK_W'(16'h5000 + k), 1'b0);
    tick();
    chk16("t4_slot0", line_data[CHUNK_W-1:0], 16'hABCD);
    tick();

    // Error clear; start-of-line at slot 0 is clean; set wins over a coincident clear.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("t5_cleared", sync_err, 1'b0);
    send(16'h6000, 1'b1);
    chk1("t5_sol_clean", sync_err, 1'b0);
    chkn("t5_sol_idx", chunk_idx, IDX_W'(1));
    send(16'h6001, 1'b0);
    send(16'h6002, 1'b0);
    clr_err = 1'b1;
    send(16'h7777, 1'b1);
    clr_err = 1'b0;
    chk1("t5_set_wins", sync_err, 1'b1);
    for (int k = 1; k < CHUNKS; k++) send(CHUNK_W'(16'h7000 + k), 1'b0);
    tick();
    tick();

    // Writes offered during FLUSH are ignored (no capture, no error).
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    line_ready = 1'b0;
    send_line(16'h8000);
    tick();
    send_line(16'hC000);
    in_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = CHUNK_W'(16'hDEAD ^ i);
      in_sol  = (i == 2);
      tick();
      chk1("t6_in_ready_low", in_ready, 1'b0);
      chkn("t6_idx_hold", chunk_idx, IDX_W'(CHUNKS - 1));
      chk1("t6_no_err", sync_err, 1'b0);
    end
    in_wr_en   = 1'b0;
    in_sol     = 1'b0;
    line_ready = 1'b1;
    tick();
    tick();
    send_line(16'h9000);
    tick();
    tick();
    chkn("t6_idx_zero", chunk_idx, '0);

    // Asynchronous reset mid-fill.
    for (int k = 0; k < 15; k++) send(CHUNK_W'(16'hE000 + k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t7_fill_rst_valid", line_valid, 1'b0);
    chkl("t7_fill_rst_data", line_data, '0);
    chkn("t7_fill_rst_idx", chunk_idx, '0);
    chk1("t7_fill_rst_ready", in_ready, 1'b1);
    exp_q.delete();
    m_idx = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_line(16'hA000);
    tick();
    tick();
    chk1("t7_fill_line_done", line_valid, 1'b0);

    // Asynchronous reset during FLUSH with a pending output line.
    line_ready = 1'b0;
    send_line(16'h1100);
    tick();
    send_line(16'h2200);
    chk1("t7_flush_stuck", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t7_flush_rst_valid", line_valid, 1'b0);
    chkl("t7_flush_rst_data", line_data, '0);
    chkn("t7_flush_rst_idx", chunk_idx, '0);
    chk1("t7_flush_rst_ready", in_ready, 1'b1);
    exp_q.delete();
    m_idx = 0;
    tick();
    rst_n = 1'b1;
    line_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t7_no_stale_valid", line_valid, 1'b0);
    end
    send_line(16'h3300);
    tick();
    tick();

    // All expected lines consumed.
    chk1("final_queue_empty", exp_q.size() == 0, 1'b1);
    chk1("final_line_count", lines_seen == 10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
